// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: load one frame of DEPTH beats, run num_iter compute
// iterations, launch a drain, then pulse frame_done.
module frame_seq_ctrl #(
   parameter int unsigned DEPTH         = 2500,
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned ITER_WIDTH    = 16
) (
   input  logic                     m00_axis_aclk,
   input  logic                     m00_axis_aresetn,
   input  logic                     start,
   input  logic                     abort,
   input  logic [ITER_WIDTH-1:0]    num_iter,
   input  logic                     s_tvalid,
   input  logic                     s_tready,
   input  logic                     s_tlast,
   output logic                     load_en,
   output logic                     compute_start,
   input  logic                     compute_done,
   output logic                     drain_start,
   input  logic                     drain_done,
   output logic                     busy,
   output logic                     frame_done,
   output logic [ADDRESS_WIDTH-1:0] pixel_count,
   output logic [ITER_WIDTH-1:0]    iter_count,
   output logic                     err_early_last,
   output logic                     err_missing_last
);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pixel_count_q, pixel_count_d;
   logic [ITER_WIDTH-1:0]    iter_count_q, iter_count_d;
   logic [ITER_WIDTH-1:0]    num_iter_q, num_iter_d;
   logic                     err_early_q, err_early_d;
   logic                     err_missing_q, err_missing_d;
   logic                     compute_start_q, compute_start_d;
   logic                     drain_start_q, drain_start_d;
   logic                     beat;
   logic [ITER_WIDTH-1:0]    iter_next;

   always_comb begin
      state_d         = state_q;
      pixel_count_d   = pixel_count_q;
      iter_count_d    = iter_count_q;
      num_iter_d      = num_iter_q;
      err_early_d     = err_early_q;
      err_missing_d   = err_missing_q;
      compute_start_d = 1'b0;
      drain_start_d   = 1'b0;
      beat            = s_tvalid & s_tready;
      iter_next       = iter_count_q + ITER_WIDTH'(1);

      // abort overrides everything: no pulses scheduled, counters and flags hold
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && (num_iter != '0)) begin
                  num_iter_d    = num_iter;
                  pixel_count_d = '0;
                  iter_count_d  = '0;
                  err_early_d   = 1'b0;
                  err_missing_d = 1'b0;
                  state_d       = LOAD;
               end
            end
            LOAD: begin
               if (beat) begin
                  pixel_count_d = pixel_count_q + ADDRESS_WIDTH'(1);
                  if (pixel_count_q == LAST_IDX) begin
                     state_d         = COMPUTE;
                     compute_start_d = 1'b1;
                     if (!s_tlast) err_missing_d = 1'b1;
                  end else if (s_tlast) begin
                     err_early_d = 1'b1;
                     state_d     = IDLE;
                  end
               end
            end
            COMPUTE: begin
               // a done coinciding with the start pulse belongs to no iteration
               if (compute_done && !compute_start_q) begin
                  iter_count_d = iter_next;
                  if (iter_next == num_iter_q) begin
                     state_d       = DRAIN;
                     drain_start_d = 1'b1;
                  end else begin
                     compute_start_d = 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_done && !drain_start_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge m00_axis_aclk) begin
      if (!m00_axis_aresetn) begin
         state_q         <= IDLE;
         pixel_count_q   <= '0;
         iter_count_q    <= '0;
         num_iter_q      <= '0;
         err_early_q     <= 1'b0;
         err_missing_q   <= 1'b0;
         compute_start_q <= 1'b0;
         drain_start_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         pixel_count_q   <= pixel_count_d;
         iter_count_q    <= iter_count_d;
         num_iter_q      <= num_iter_d;
         err_early_q     <= err_early_d;
         err_missing_q   <= err_missing_d;
         compute_start_q <= compute_start_d;
         drain_start_q   <= drain_start_d;
      end
   end

   assign load_en          = (state_q == LOAD);
   assign busy             = (state_q != IDLE);
   assign frame_done       = (state_q == DONE);
   assign compute_start    = compute_start_q;
   assign drain_start      = drain_start_q;
   assign pixel_count      = pixel_count_q;
   assign iter_count       = iter_count_q;
   assign err_early_last   = err_early_q;
   assign err_missing_last = err_missing_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl; pulse outputs are checked by a
// scoreboard monitor, status outputs by direct comparisons.
module tb_frame_seq_ctrl;

   localparam int DEPTH = 2500;
   localparam int AW    = 12;
   localparam int IW    = 16;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          start, abort;
   logic [IW-1:0] num_iter;
   logic          s_tvalid, s_tready, s_tlast;
   logic          load_en, compute_start, compute_done;
   logic          drain_start, drain_done, busy, frame_done;
   logic [AW-1:0] pixel_count;
   logic [IW-1:0] iter_count;
   logic          err_early_last, err_missing_last;

   typedef struct {
      int kind;   // 0 compute_start, 1 drain_start, 2 frame_done
      int iter;
      int pix;
      int ee;
      int em;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk = 0;
   int  n_err = 0;

   frame_seq_ctrl #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .ITER_WIDTH(IW)) dut (
      .m00_axis_aclk    (clk),
      .m00_axis_aresetn (aresetn),
      .start            (start),
      .abort            (abort),
      .num_iter         (num_iter),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .s_tlast          (s_tlast),
      .load_en          (load_en),
      .compute_start    (compute_start),
      .compute_done     (compute_done),
      .drain_start      (drain_start),
      .drain_done       (drain_done),
      .busy             (busy),
      .frame_done       (frame_done),
      .pixel_count      (pixel_count),
      .iter_count       (iter_count),
      .err_early_last   (err_early_last),
      .err_missing_last (err_missing_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every pulse output must match the next expected event
   always @(negedge clk) begin
      ev_t e;
      int  k;
      if (aresetn && (compute_start || drain_start || frame_done)) begin
         k = compute_start ? 0 : (drain_start ? 1 : 2);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_pulse: got kind %0d expected none at %0t", k, $time);
         end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_iter_count", int'(iter_count), e.iter);
            chk("ev_pixel_count", int'(pixel_count), e.pix);
            chk("ev_err_early", int'(err_early_last), e.ee);
            chk("ev_err_missing", int'(err_missing_last), e.em);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int n, input int em);
      for (int k = 0; k < n; k++) exp_q.push_back('{0, k, DEPTH, 0, em});
      exp_q.push_back('{1, n, DEPTH, 0, em});
      exp_q.push_back('{2, n, DEPTH, 0, em});
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_load_en"}, int'(load_en), 0);
      chk({tag, "_compute_start"}, int'(compute_start), 0);
      chk({tag, "_drain_start"}, int'(drain_start), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_pixel_count"}, int'(pixel_count), 0);
      chk({tag, "_iter_count"}, int'(iter_count), 0);
      chk({tag, "_err_early"}, int'(err_early_last), 0);
      chk({tag, "_err_missing"}, int'(err_missing_last), 0);
   endtask

   task automatic start_frame(input int n);
      start    = 1'b1;
      num_iter = IW'(n);
      tick();
      start    = 1'b0;
      num_iter = '0;
   endtask

   task automatic load_beats(input int count, input int last_at);
      for (int i = 1; i <= count; i++) begin
         s_tvalid = 1'b1;
         s_tready = 1'b1;
         s_tlast  = (i == last_at);
         tick();
      end
      s_tvalid = 1'b0;
      s_tready = 1'b0;
      s_tlast  = 1'b0;
      chk("load_pixel_count", int'(pixel_count), count);
   endtask

   // each pass starts in a compute_start cycle; done follows four cycles later
   task automatic run_iters(input int n, input bit disturb);
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 4; j++) begin
            if (disturb && k == 0 && j == 0) compute_done = 1'b1;
            if (disturb && k == 0 && j == 1) begin
               start    = 1'b1;
               num_iter = IW'(7);
               s_tvalid = 1'b1;
               s_tready = 1'b1;
               s_tlast  = 1'b1;
            end
            tick();
            compute_done = 1'b0;
            start        = 1'b0;
            num_iter     = '0;
            s_tvalid     = 1'b0;
            s_tready     = 1'b0;
            s_tlast      = 1'b0;
            if (disturb && k == 0 && j == 1) begin
               chk("pix_hold_in_compute", int'(pixel_count), DEPTH);
               chk("busy_start_ignored", int'(busy), 1);
               chk("iter_done_during_start_ignored", int'(iter_count), 0);
            end
         end
         compute_done = 1'b1;
         tick();
         compute_done = 1'b0;
      end
   endtask

   task automatic drain_phase();
      drain_done = 1'b1;   // lands in the drain_start cycle, must be ignored
      tick();
      drain_done = 1'b0;
      repeat (8) tick();
      chk("busy_in_drain", int'(busy), 1);
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      tick();
      chk("busy_after_frame", int'(busy), 0);
      chk("frame_done_one_cycle", int'(frame_done), 0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0; start = 1'b0; abort = 1'b0; num_iter = '0;
      s_tvalid = 1'b0; s_tready = 1'b0; s_tlast = 1'b0;
      compute_done = 1'b0; drain_done = 1'b0;
      repeat (3) tick();
      check_idle_zero("reset");
      aresetn = 1'b1;
      tick();

      start_frame(0);
      chk("zero_iter_busy", int'(busy), 0);
      chk("zero_iter_load_en", int'(load_en), 0);

      abort = 1'b1; start = 1'b1; num_iter = IW'(3);
      tick();
      abort = 1'b0; start = 1'b0; num_iter = '0;
      chk("abort_beats_start", int'(busy), 0);

      // nominal frame, with start/beat/early done injected during compute
      start_frame(3);
      chk("nom_busy", int'(busy), 1);
      chk("nom_load_en", int'(load_en), 1);
      push_frame(3, 0);
      load_beats(DEPTH, DEPTH);
      chk("nom_load_en_off", int'(load_en), 0);
      run_iters(3, 1'b1);
      drain_phase();
      chk("nom_iter_count", int'(iter_count), 3);
      chk("nom_pixel_count", int'(pixel_count), DEPTH);

      // early tlast at beat 100
      start_frame(2);
      load_beats(100, 100);
      chk("early_err", int'(err_early_last), 1);
      chk("early_missing_clear", int'(err_missing_last), 0);
      chk("early_busy", int'(busy), 0);
      repeat (10) tick();

      // no tlast on final beat
      start_frame(1);
      chk("missing_clears_early", int'(err_early_last), 0);
      push_frame(1, 1);
      load_beats(DEPTH, 0);
      chk("missing_err", int'(err_missing_last), 1);
      run_iters(1, 1'b0);
      drain_phase();

      // abort after one completed iteration
      start_frame(2);
      chk("restart_clears_missing", int'(err_missing_last), 0);
      exp_q.push_back('{0, 0, DEPTH, 0, 0});
      exp_q.push_back('{0, 1, DEPTH, 0, 0});
      load_beats(DEPTH, DEPTH);
      run_iters(1, 1'b0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_iter_hold", int'(iter_count), 1);
      chk("abort_pix_hold", int'(pixel_count), DEPTH);
      repeat (20) tick();

      // reset in the middle of loading
      start_frame(1);
      load_beats(1200, 0);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      check_idle_zero("midreset");

      start_frame(2);
      push_frame(2, 0);
      load_beats(DEPTH, DEPTH);
      run_iters(2, 1'b0);
      drain_phase();
      chk("post_reset_iter_count", int'(iter_count), 2);

      repeat (5) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
